// File: rtl/i2c_slave.sv
// I2C target: synchronised and glitch-filtered SCL/SDA, 7-bit address match, byte RX/TX handshake.
// Optional clock stretching (RX ACK and TX load) is enabled by defining I2C_SLAVE_CLOCK_STRETCH_EN.
module i2c_slave #(
    parameter logic [6:0] ADDRESS      = 7'h50,
    parameter int         FILTER_DEPTH = 3
) (
    input  logic       clk_in,
    input  logic       reset,
    inout  wire        scl,
    inout  wire        sda,
    output logic       addressed,
    output logic       mode,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    input  logic       ack_enable,
    input  logic [7:0] data_tx,
    output logic       tx_load,
    output logic       nack,
    output logic       start_det,
    output logic       stop_det,
    input  logic       host_ready,
    output logic       stretching
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
    } state_t;

    localparam int CW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;

    state_t        state, next_state;
    logic [1:0]    raw, meta, syncd, filt, filt_q;   // bit 1 = SCL, bit 0 = SDA
    logic [CW-1:0] cnt [2];
    logic          scl_f, sda_f, scl_rise, scl_fall, start_cond, stop_cond;
    logic [2:0]    bit_cnt;
    logic          byte_done, ack_q, sda_low, tx_entry, tx_fire;
    logic [7:0]    shift_reg;
    logic [6:0]    tx_sr;

    assign raw = {scl, sda};

    // A filtered level only follows the synchronised input after FILTER_DEPTH differing samples in a row.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta   <= '1;
            syncd  <= '1;
            filt   <= '1;
            filt_q <= '1;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            meta   <= raw;
            syncd  <= meta;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (syncd[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILTER_DEPTH - 1)) begin
                    filt[i] <= syncd[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign scl_f      = filt[1];
    assign sda_f      = filt[0];
    assign scl_rise   = scl_f & ~filt_q[1];
    assign scl_fall   = ~scl_f & filt_q[1];
    assign start_cond = scl_f & filt_q[1] & filt_q[0] & ~sda_f;
    assign stop_cond  = scl_f & filt_q[1] & ~filt_q[0] & sda_f;

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    logic scl_low, hold;
    assign scl        = scl_low ? 1'b0 : 1'bz;
    assign stretching = scl_low;
`else
    logic unused_host_ready;
    assign unused_host_ready = host_ready;
    assign scl               = 1'bz;
    assign stretching        = 1'b0;
`endif
    assign sda = sda_low ? 1'b0 : 1'bz;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        next_state = state;
        tx_entry   = 1'b0;
        if (start_cond) begin
            next_state = ADDR;
        end else if (stop_cond) begin
            next_state = IDLE;
        end else begin
            case (state)
                ADDR:     if (scl_fall && byte_done)
                              next_state = (shift_reg[7:1] == ADDRESS) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall) begin
                              next_state = mode ? TX : RX;
                              tx_entry   = mode;
                          end
                RX:       if (scl_fall && byte_done) next_state = RX_ACK;
                RX_ACK:   if (scl_fall) next_state = ack_q ? RX : IGNORE;
                TX:       if (scl_fall && byte_done) next_state = TX_ACK;
                TX_ACK:   if (scl_rise && sda_f) begin
                              next_state = IGNORE;
                          end else if (scl_fall) begin
                              next_state = TX;
                              tx_entry   = 1'b1;
                          end
                IDLE, IGNORE: next_state = state;
                default:  next_state = IDLE;
            endcase
        end
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
        // With stretching the byte is fetched only once the host has released the hold.
        tx_fire = hold && host_ready && (state == TX) && !start_cond && !stop_cond;
`else
        tx_fire = tx_entry;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            shift_reg <= '0;
            tx_sr     <= '0;
            data_rx   <= '0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            addressed <= 1'b0;
            mode      <= 1'b0;
            nack      <= 1'b0;
            ack_q     <= 1'b0;
            sda_low   <= 1'b0;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
            scl_low   <= 1'b0;
            hold      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge register values.
            state     <= next_state;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            start_det <= start_cond;
            stop_det  <= stop_cond;
            if (rx_valid) ack_q <= ack_enable;

            if (start_cond || stop_cond) begin
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                addressed <= 1'b0;
                sda_low   <= 1'b0;
                if (start_cond) nack <= 1'b0;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
                scl_low   <= 1'b0;
                hold      <= 1'b0;
`endif
            end else begin
                case (state)
                    ADDR, RX: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_f};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                                if (state == RX) begin
                                    data_rx  <= {shift_reg[6:0], sda_f};
                                    rx_valid <= 1'b1;
                                end
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (state == ADDR) begin
                                if (shift_reg[7:1] == ADDRESS) begin
                                    sda_low   <= 1'b1;
                                    addressed <= 1'b1;
                                    mode      <= shift_reg[0];
                                end
                            end else begin
                                sda_low <= ack_q;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
                                scl_low <= 1'b1;
                                hold    <= 1'b1;
`endif
                            end
                        end
                    end
                    ADDR_ACK, RX_ACK: if (scl_fall) sda_low <= 1'b0;
                    TX: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                sda_low   <= 1'b0;
                            end else begin
                                sda_low <= ~tx_sr[6];
                                tx_sr   <= {tx_sr[5:0], 1'b0};
                            end
                        end
                    end
                    TX_ACK: if (scl_rise && sda_f) begin
                        nack      <= 1'b1;
                        addressed <= 1'b0;
                    end
                    default: ;
                endcase

                if (tx_entry) begin
                    bit_cnt <= '0;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
                    scl_low <= 1'b1;
                    hold    <= 1'b1;
`endif
                end
                if (tx_fire) begin
                    tx_load <= 1'b1;
                    tx_sr   <= data_tx[6:0];
                    sda_low <= ~data_tx[7];
                end
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
                if (hold && host_ready) begin
                    hold    <= 1'b0;
                    scl_low <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bit-banged bus master plus scoreboards for received and read bytes.
// Covers write, read with master NACK, address mismatch, repeated START, mid-byte reset and clock stretching.
module tb_i2c_slave;

    localparam int Q = 10;   // clk_in cycles per quarter SCL period
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    localparam int STRETCH_LEN = 50;
`else
    localparam int STRETCH_LEN = 0;
`endif

    logic       clk_in = 1'b0;
    logic       reset;
    wire        scl_bus, sda_bus;
    logic       m_scl_low, m_sda_low;
    logic       addressed, mode, rx_valid, tx_load, nack, start_det, stop_det, stretching;
    logic       ack_enable, host_ready;
    logic [7:0] data_rx, data_tx;

    int n_tests = 0;
    int n_fail  = 0;
    int rx_cnt, tx_cnt, start_cnt, stop_cnt, slave_sda_cnt, stretch_cnt, stretch_bad;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    always #5 clk_in = ~clk_in;

    pullup (scl_bus);
    pullup (sda_bus);
    assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.ADDRESS(7'h50), .FILTER_DEPTH(3)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .scl        (scl_bus),
        .sda        (sda_bus),
        .addressed  (addressed),
        .mode       (mode),
        .data_rx    (data_rx),
        .rx_valid   (rx_valid),
        .ack_enable (ack_enable),
        .data_tx    (data_tx),
        .tx_load    (tx_load),
        .nack       (nack),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .host_ready (host_ready),
        .stretching (stretching)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitors sample on the falling edge, away from the DUT's active edge.
    always @(negedge clk_in) begin
        logic [7:0] e;
        if (rx_valid) begin
            rx_cnt++;
            check("rx_expected", exp_rx.size() > 0, 1'b1);
            if (exp_rx.size() > 0) begin
                e = exp_rx.pop_front();
                check("rx_data", data_rx, e);
            end
        end
        if (tx_load) tx_cnt++;
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
        if (sda_bus === 1'b0 && !m_sda_low) slave_sda_cnt++;
        if (stretching) begin
            stretch_cnt++;
            if (scl_bus !== 1'b0) stretch_bad++;
        end
    end

    // Host answers each stretch after STRETCH_LEN cycles.
    initial begin
        host_ready = 1'b0;
        forever begin
            @(negedge clk_in);
            if (stretching) begin
                repeat (STRETCH_LEN - 1) @(negedge clk_in);
                host_ready = 1'b1;
                @(negedge clk_in);
                host_ready = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk_in);
    endtask

    task automatic scl_high();
        int n;
        m_scl_low = 1'b0;
        n = 0;
        while (scl_bus !== 1'b1 && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        if (scl_bus !== 1'b1) check("scl_release_timeout", scl_bus, 1'b1);
    endtask

    task automatic send_bit(input logic b, output logic sampled);
        m_sda_low = ~b;
        wait_q();
        scl_high();
        wait_q();
        sampled = sda_bus;
        wait_q();
        m_scl_low = 1'b1;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(~master_ack, s);
    endtask

    task automatic do_start();
        if (m_scl_low) begin
            m_sda_low = 1'b0;
            wait_q();
            scl_high();
            wait_q();
        end
        m_sda_low = 1'b1;
        wait_q();
        m_scl_low = 1'b1;
        wait_q();
    endtask

    task automatic do_stop();
        m_sda_low = 1'b1;
        wait_q();
        scl_high();
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
    endtask

    task automatic clear_counts();
        rx_cnt = 0; tx_cnt = 0; start_cnt = 0; stop_cnt = 0;
        slave_sda_cnt = 0; stretch_cnt = 0; stretch_bad = 0;
    endtask

    task automatic read_and_score(input logic master_ack, input string tag);
        logic [7:0] got, e;
        read_byte(master_ack, got);
        check({tag, "_expected"}, exp_tx.size() > 0, 1'b1);
        if (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            check(tag, got, e);
        end
    endtask

    initial begin
        logic ack;
        logic s;
        clear_counts();
        m_scl_low  = 1'b0;
        m_sda_low  = 1'b0;
        ack_enable = 1'b1;
        data_tx    = 8'h00;
        reset      = 1'b1;
        repeat (5) @(negedge clk_in);
        reset = 1'b0;
        repeat (10) @(negedge clk_in);

        check("rst_addressed",  addressed,  1'b0);
        check("rst_mode",       mode,       1'b0);
        check("rst_data_rx",    data_rx,    8'h00);
        check("rst_pulses",     {rx_valid, tx_load, start_det, stop_det}, 4'b0000);
        check("rst_nack",       nack,       1'b0);
        check("rst_stretching", stretching, 1'b0);
        check("rst_lines",      {scl_bus, sda_bus}, 2'b11);

        // Write: address 0x50 + W, one data byte.
        clear_counts();
        do_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", ack, 1'b1);
        check("wr_addressed", addressed, 1'b1);
        exp_rx.push_back(8'hB4);
        write_byte(8'hB4, ack);
        check("wr_data_ack", ack, 1'b1);
        do_stop();
        wait_q();
        check("wr_rx_cnt",      rx_cnt,    1);
        check("wr_data_rx",     data_rx,   8'hB4);
        check("wr_start_cnt",   start_cnt, 1);
        check("wr_stop_cnt",    stop_cnt,  1);
        check("wr_addr_after",  addressed, 1'b0);
        check("wr_mode",        mode,      1'b0);
        check("wr_stretch_len", stretch_cnt, STRETCH_LEN);
        check("wr_stretch_scl", stretch_bad, 0);

        // Read: address 0x50 + R, master NACKs the single byte.
        clear_counts();
        data_tx = 8'hB4;
        exp_tx.push_back(8'hB4);
        do_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 1'b1);
        check("rd_mode", mode, 1'b1);
        read_and_score(1'b0, "rd_byte");
        wait_q();
        check("rd_tx_cnt",    tx_cnt,    1);
        check("rd_nack",      nack,      1'b1);
        check("rd_addressed", addressed, 1'b0);
        check("rd_stretch_len", stretch_cnt, STRETCH_LEN);
        do_stop();
        wait_q();
        check("rd_nack_held", nack, 1'b1);

        // Address mismatch: the target stays silent until STOP.
        clear_counts();
        do_start();
        write_byte(8'hA2, ack);
        check("mm_addr_nack", ack, 1'b0);
        write_byte(8'h55, ack);
        check("mm_data_nack", ack, 1'b0);
        do_stop();
        wait_q();
        check("mm_sda_driven", slave_sda_cnt, 0);
        check("mm_pulses", rx_cnt + tx_cnt, 0);
        check("mm_addressed", addressed, 1'b0);

        // Write 0x12, repeated START, read two bytes (ACK then NACK).
        clear_counts();
        do_start();
        check("rs_nack_clr", nack, 1'b0);
        write_byte(8'hA0, ack);
        check("rs_waddr_ack", ack, 1'b1);
        exp_rx.push_back(8'h12);
        write_byte(8'h12, ack);
        check("rs_wdata_ack", ack, 1'b1);
        data_tx = 8'hCA;
        exp_tx.push_back(8'hCA);
        exp_tx.push_back(8'hCA);
        do_start();
        write_byte(8'hA1, ack);
        check("rs_raddr_ack", ack, 1'b1);
        check("rs_mode", mode, 1'b1);
        read_and_score(1'b1, "rs_byte0");
        read_and_score(1'b0, "rs_byte1");
        do_stop();
        wait_q();
        check("rs_data_rx",   data_rx,   8'h12);
        check("rs_tx_cnt",    tx_cnt,    2);
        check("rs_start_cnt", start_cnt, 2);
        check("rs_nack",      nack,      1'b1);

        // Reset at bit 4 of a received byte.
        clear_counts();
        do_start();
        write_byte(8'hA0, ack);
        check("rr_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, s);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        check("rr_sda_released", sda_bus, 1'b1);
        check("rr_not_stretching", stretching, 1'b0);
        check("rr_addressed", addressed, 1'b0);
        check("rr_data_rx", data_rx, 8'h00);
        for (int i = 0; i < 4; i++) send_bit(1'b0, s);
        send_bit(1'b1, s);
        check("rr_byte_ignored", s, 1'b1);
        do_stop();
        wait_q();
        check("rr_rx_cnt", rx_cnt, 0);
        do_start();
        write_byte(8'hA0, ack);
        check("rr_readdr_ack", ack, 1'b1);
        exp_rx.push_back(8'h5A);
        write_byte(8'h5A, ack);
        check("rr_data_ack", ack, 1'b1);
        do_stop();
        wait_q();
        check("rr_data_rx_new", data_rx, 8'h5A);
        check("rr_rx_cnt_new", rx_cnt, 1);

        check("rx_queue_empty", exp_rx.size(), 0);
        check("tx_queue_empty", exp_tx.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
